// File: rtl/song_player.sv
// song_player: auto-play sequencer that walks a {note, dur} song ROM
// and drives a 10-bit keyboard-format note word while in PLAY mode.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   enable           high while the system is in PLAY mode
//   start            one-cycle pulse, (re)start the song at address 0
//   pause            level, freeze playback while high
//   loop             level, restart at address 0 on song end
//   rom_addr         song ROM address (synchronous ROM, 1-cycle latency)
//   rom_data         {note[9:0], dur[3:0]}, dur=0 marks end of song
//   note_out         current note word, 0 = silence
//   playing          high in FETCH, LOAD, PLAY, GAP and PAUSED
//   done             one-cycle pulse on entering DONE
//   note_idx         address of the sounding entry (same as rom_addr)
module song_player #(
   parameter int TICK_DIV = 12_500_000,
   parameter int GAP_CYC  = 1_000_000,
   parameter int ADDR_W   = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              start,
   input  logic              pause,
   input  logic              loop,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [13:0]       rom_data,
   output logic [9:0]        note_out,
   output logic              playing,
   output logic              done,
   output logic [ADDR_W-1:0] note_idx
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_PLAY,
      S_GAP,
      S_PAUSED,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              r_saved;
   logic [ADDR_W-1:0]   r_addr;
   logic [9:0]          r_note;
   logic [9:0]          r_out;
   logic [PRE_W-1:0]    r_pre;
   logic [3:0]          r_dur;
   logic [GAP_W-1:0]    r_gap;
   logic                r_playing;
   logic                r_done;

   state_t              w_state;
   state_t              w_saved;
   logic [ADDR_W-1:0]   w_addr;
   logic [9:0]          w_note;
   logic [9:0]          w_out;
   logic [PRE_W-1:0]    w_pre;
   logic [3:0]          w_dur;
   logic [GAP_W-1:0]    w_gap;
   logic                w_playing;
   logic                w_done;
   logic                w_adv;
   logic                w_end;
   logic                w_mark0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_saved   <= S_PLAY;
         r_addr    <= '0;
         r_note    <= '0;
         r_out     <= '0;
         r_pre     <= '0;
         r_dur     <= '0;
         r_gap     <= '0;
         r_playing <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_saved   <= w_saved;
         r_addr    <= w_addr;
         r_note    <= w_note;
         r_out     <= w_out;
         r_pre     <= w_pre;
         r_dur     <= w_dur;
         r_gap     <= w_gap;
         r_playing <= w_playing;
         r_done    <= w_done;
      end
   end

   always_comb begin
      w_state = r_state;
      w_saved = r_saved;
      w_addr  = r_addr;
      w_note  = r_note;
      w_out   = r_out;
      w_pre   = r_pre;
      w_dur   = r_dur;
      w_gap   = r_gap;
      w_adv   = 1'b0;
      w_end   = 1'b0;
      w_mark0 = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            w_out  = '0;
            w_addr = '0;
         end
         S_FETCH: begin
            w_out   = '0;
            w_state = S_LOAD;
         end
         S_LOAD: begin
            if (rom_data[3:0] == 4'd0) begin
               w_end   = 1'b1;
               w_mark0 = (r_addr == '0);
            end else begin
               w_note  = rom_data[13:4];
               w_out   = rom_data[13:4];
               w_dur   = rom_data[3:0];
               w_pre   = '0;
               w_state = S_PLAY;
            end
         end
         S_PLAY: begin
            if (r_pre == PRE_MAX) begin
               w_pre = '0;
               w_dur = r_dur - 4'd1;
               if (r_dur == 4'd1) begin
                  w_out = '0;
                  if (GAP_CYC > 0) begin
                     w_gap   = '0;
                     w_state = S_GAP;
                  end else begin
                     w_adv = 1'b1;
                  end
               end
            end else begin
               w_pre = r_pre + PRE_W'(1);
            end
         end
         S_GAP: begin
            if (r_gap == GAP_MAX) w_adv = 1'b1;
            else w_gap = r_gap + GAP_W'(1);
         end
         S_PAUSED: begin
            if (!pause) begin
               w_state = r_saved;
               w_out   = (r_saved == S_PLAY) ? r_note : '0;
            end
         end
         S_DONE: begin
            w_out = '0;
         end
         default: begin
            w_state = S_IDLE;
            w_out   = '0;
            w_addr  = '0;
         end
      endcase

      // last entry of the ROM has no successor: treat as song end
      if (w_adv) begin
         if (&r_addr) begin
            w_end = 1'b1;
         end else begin
            w_addr  = r_addr + ADDR_W'(1);
            w_state = S_FETCH;
         end
      end

      // an end marker at address 0 is an empty song; never loop on it
      if (w_end) begin
         if (loop && !w_mark0) begin
            w_addr  = '0;
            w_state = S_FETCH;
         end else begin
            w_state = S_DONE;
         end
      end

      // the cycle that sees pause still counts; only the next one freezes
      if (pause &&
          (r_state == S_PLAY || r_state == S_GAP) &&
          (w_state == S_PLAY || w_state == S_GAP)) begin
         w_saved = w_state;
         w_state = S_PAUSED;
         w_out   = '0;
      end

      if (start && enable) begin
         w_state = S_FETCH;
         w_addr  = '0;
         w_out   = '0;
      end

      if (!enable) begin
         w_state = S_IDLE;
         w_addr  = '0;
         w_out   = '0;
      end

      w_playing = (w_state == S_FETCH) || (w_state == S_LOAD) ||
                  (w_state == S_PLAY)  || (w_state == S_GAP)  ||
                  (w_state == S_PAUSED);
      w_done    = (w_state == S_DONE) && (r_state != S_DONE);
   end

   assign rom_addr = r_addr;
   assign note_idx = r_addr;
   assign note_out = r_out;
   assign playing  = r_playing;
   assign done     = r_done;

endmodule
